// File: rtl/quantum_bit_harvester.sv
`default_nettype none
// ============================================================================
// Module      : quantum_bit_harvester
// Description : Von Neumann debiaser for a raw quantum random bit stream with
//               a repetition-count health test and a small output byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module quantum_bit_harvester #(
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       raw_bit,
    input  logic       raw_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic       health_fail
);

    localparam int              c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [4:0]      c_depth     = 5'(FIFO_DEPTH);
    localparam logic [7:0]      c_rep_limit = 8'(REP_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_rst_sync;
    logic                 w_run;
    logic                 r_pair;
    logic                 r_last;
    logic [7:0]           r_rep;
    logic [7:0]           w_rep_next;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_ovf;
    logic                 r_health;
    logic                 w_sample;
    logic                 w_trip;
    logic                 w_emit;
    logic                 w_push;
    logic [7:0]           w_byte;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [4:0]           r_count;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_do_push;
    logic                 w_drop;

    // Reset release synchroniser: sampling is held off until two edges after deassertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_run = r_rst_sync[1];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Sampling, health test, debias decision and next-state logic
    always_comb begin
        w_state_next = r_state;
        w_rep_next   = r_rep;
        w_sample     = enable & raw_valid & w_run &
                       ((r_state == S_FIRST) | (r_state == S_SECOND));
        if (w_sample) begin
            if ((r_rep == 8'd0) || (raw_bit != r_last)) w_rep_next = 8'd1;
            else if (r_rep != 8'hFF)                    w_rep_next = r_rep + 8'd1;
        end
        w_trip = w_sample && (w_rep_next >= c_rep_limit);
        // Only a 01 or 10 pair yields a bit; the bit is the first of the pair
        w_emit = w_sample && !w_trip && (r_state == S_SECOND) && (raw_bit != r_pair);
        w_byte = {r_shift[6:0], r_pair};
        w_push = w_emit && (r_bit_cnt == 3'd7);
        case (r_state)
            S_IDLE: begin
                if (enable && w_run) w_state_next = S_FIRST;
            end
            S_FIRST: begin
                if (!enable)      w_state_next = S_IDLE;
                else if (w_trip)  w_state_next = S_FAULT;
                else if (w_sample) w_state_next = S_SECOND;
            end
            S_SECOND: begin
                if (!enable)      w_state_next = S_IDLE;
                else if (w_trip)  w_state_next = S_FAULT;
                else if (w_sample) w_state_next = S_FIRST;
            end
            default: w_state_next = S_FAULT;
        endcase
        if (clear) w_state_next = S_IDLE;
    end

    // Extractor datapath: pair bit, shifter, counters and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair    <= 1'b0;
            r_last    <= 1'b0;
            r_rep     <= 8'd0;
            r_shift   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_ovf     <= 1'b0;
            r_health  <= 1'b0;
        end else if (clear) begin
            r_pair    <= 1'b0;
            r_last    <= 1'b0;
            r_rep     <= 8'd0;
            r_shift   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_ovf     <= 1'b0;
            r_health  <= 1'b0;
        end else begin
            if (w_sample) begin
                r_rep  <= w_rep_next;
                r_last <= raw_bit;
                if (r_state == S_FIRST) r_pair <= raw_bit;
            end
            if (w_emit) begin
                r_shift   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_trip) r_health <= 1'b1;
            if (w_drop) r_ovf    <= 1'b1;
        end
    end

    assign w_pop     = byte_valid & byte_ready;
    assign w_full    = (r_count == c_depth);
    // A full FIFO can still accept a byte when the head leaves on the same edge
    assign w_do_push = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only observable while the entry is valid
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) r_mem[r_wr_ptr] <= w_byte;
    end

    assign byte_valid  = (r_count != 5'd0);
    assign byte_out    = byte_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_count  = r_count;
    assign overflow    = r_ovf;
    assign health_fail = r_health;

endmodule
`default_nettype wire

// File: tb/tb_quantum_bit_harvester.sv
`default_nettype none
// ============================================================================
// Module      : tb_quantum_bit_harvester
// Description : Randomised self-checking bench for quantum_bit_harvester with
//               a queue-based reference model of the extractor and FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quantum_bit_harvester;

    localparam int FIFO_DEPTH = 4;
    localparam int REP_LIMIT  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       health_fail;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_ovf, m_hf, m_fault, m_have, m_first, m_last;
    logic [7:0] m_sh;
    int         m_nb, m_rep;

    quantum_bit_harvester #(.FIFO_DEPTH(FIFO_DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .raw_bit(raw_bit), .raw_valid(raw_valid), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .fifo_count(fifo_count),
        .overflow(overflow), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_hf = 0; m_fault = 0; m_have = 0; m_first = 0; m_last = 0;
        m_sh = 8'h00; m_nb = 0; m_rep = 0;
    endtask

    task automatic check_outputs();
        chk("byte_valid", byte_valid, (m_q.size() != 0));
        chk("fifo_count", fifo_count, m_q.size());
        chk("overflow", overflow, m_ovf);
        chk("health_fail", health_fail, m_hf);
        if (m_q.size() != 0) chk("byte_out", byte_out, m_q[0]);
    endtask

    // One clock: drive inputs, advance the model by the same edge, compare
    task automatic cycle(input logic v, input logic b, input logic rdy, input logic clr);
        logic pop, push;
        logic [7:0] pb;
        raw_valid = v; raw_bit = b; byte_ready = rdy; clear = clr;
        pop = rdy && (m_q.size() != 0);
        push = 0; pb = 8'h00;
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            if (v && !m_fault) begin
                m_rep  = (m_rep == 0 || b != m_last) ? 1 : ((m_rep < 255) ? m_rep + 1 : 255);
                m_last = b;
                if (m_rep >= REP_LIMIT) begin
                    m_hf = 1; m_fault = 1;
                end else if (!m_have) begin
                    m_first = b; m_have = 1;
                end else begin
                    m_have = 0;
                    if (b != m_first) begin
                        m_sh = {m_sh[6:0], m_first};
                        m_nb = m_nb + 1;
                        if (m_nb == 8) begin
                            m_nb = 0; push = 1; pb = m_sh;
                        end
                    end
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(pb);
                else m_ovf = 1;
            end
        end
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Emit one byte MSB-first as debiased pairs (b, ~b)
    task automatic feed_byte(input logic [7:0] val, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b1, val[i], 1'b0, 1'b0);
            cycle(1'b1, ~val[i], (i == 0) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    task automatic do_clear();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
    endtask

    initial begin
        logic [7:0] bytes [5];
        logic [7:0] rb;
        logic       clr_prev;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", byte_valid, 1'b0);
        chk("rst_count", fifo_count, 5'd0);
        chk("rst_byte", byte_out, 8'h00);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_hf", health_fail, 1'b0);
        rst_n = 1'b1;
        enable = 1'b1;
        idle(4, 1'b0);

        // 0,1 repeated: eight 0 bits -> 0x00
        for (int i = 0; i < 16; i++) cycle(1'b1, i[0], 1'b0, 1'b0);
        chk("alt01_count", fifo_count, 5'd1);
        chk("alt01_valid", byte_valid, 1'b1);
        chk("alt01_byte", byte_out, 8'h00);
        idle(1, 1'b1);

        // 1,0 repeated then 00/11 pairs -> 0xFF and nothing more
        for (int i = 0; i < 16; i++) cycle(1'b1, ~i[0], 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("alt10_byte", byte_out, 8'hFF);
        chk("alt10_count", fifo_count, 5'd1);
        idle(1, 1'b1);
        // Seven more bits must not complete a byte if the equal pairs emitted nothing
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("eq_pairs_silent", fifo_count, 5'd0);
        do_clear();

        // Overflow: five bytes into a four-deep FIFO, nothing consumed
        for (int k = 0; k < 5; k++) begin
            bytes[k] = 8'($urandom);
            feed_byte(bytes[k], 1'b0);
        end
        chk("ovf_count", fifo_count, 5'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head", byte_out, bytes[0]);
        do_clear();
        chk("clr_count", fifo_count, 5'd0);
        chk("clr_ovf", overflow, 1'b0);

        // Full FIFO with a pop on the completing edge: no overflow
        for (int k = 0; k < 4; k++) feed_byte(8'($urandom), 1'b0);
        feed_byte(8'($urandom), 1'b1);
        chk("popfull_ovf", overflow, 1'b0);
        chk("popfull_count", fifo_count, 5'd4);
        do_clear();

        // Health test: sixteen 1s trip on the sixteenth
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 14) chk("hf_15", health_fail, 1'b0);
        end
        chk("hf_16", health_fail, 1'b1);
        for (int i = 0; i < 32; i++) cycle(1'b1, i[0], 1'b0, 1'b0);
        chk("fault_nopush", fifo_count, 5'd0);
        chk("fault_hold", health_fail, 1'b1);
        do_clear();
        chk("hf_clr", health_fail, 1'b0);
        chk("hf_clr_ovf", overflow, 1'b0);
        chk("hf_clr_count", fifo_count, 5'd0);

        // Randomised traffic with occasional clears
        clr_prev = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic c;
            c = (!clr_prev) && ($urandom_range(0, 79) == 0);
            cycle(clr_prev ? 1'b0 : 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom_range(0, 3) == 0), c);
            clr_prev = c;
        end
        do_clear();

        // Asynchronous reset mid-byte discards partial data and the FIFO
        feed_byte(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", byte_valid, 1'b0);
        chk("arst_count", fifo_count, 5'd0);
        chk("arst_byte", byte_out, 8'h00);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4, 1'b0);
        rb = 8'($urandom);
        feed_byte(rb, 1'b0);
        chk("post_rst_count", fifo_count, 5'd1);
        chk("post_rst_byte", byte_out, rb);
        idle(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/quantum_bit_harvester.md
QUANTUM_BIT_HARVESTER -- requirements
Module: quantum_bit_harvester

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output byte entries (power of two, 2..16).
REQ-002 The block SHALL have parameter REP_LIMIT, default 16, meaning the number of consecutive identical raw samples that trips the health test (2..255).
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port enable  input  1  high = sample raw stream; low = hold all state.
REQ-006 The block SHALL have port clear  input  1  synchronous flush of all datapath state and flags.
REQ-007 The block SHALL have port raw_bit  input  1  raw random bit from the upstream quantum number generator.
REQ-008 The block SHALL have port raw_valid  input  1  raw_bit is sampled on each edge where raw_valid=1 and enable=1.
REQ-009 The block SHALL have port byte_out  output  8  FIFO head byte.
REQ-010 The block SHALL have port byte_valid  output  1  FIFO non-empty.
REQ-011 The block SHALL have port byte_ready  input  1  consumer accepts byte_out when byte_valid=1.
REQ-012 The block SHALL have port fifo_count  output  5  number of FIFO entries held.
REQ-013 The block SHALL have port overflow  output  1  sticky: a completed byte was dropped.
REQ-014 The block SHALL have port health_fail  output  1  sticky: repetition test tripped.

Function
REQ-015 The extractor FSM SHALL have states IDLE, FIRST, SECOND and FAULT.
REQ-016 The FSM SHALL go IDLE->FIRST when enable=1, and any state except FAULT ->IDLE when enable=0, keeping the pair bit, shifter and counters.
REQ-017 In FIRST, a sample SHALL store raw_bit as the pair bit, and the FSM SHALL go to SECOND.
REQ-018 In SECOND, a sample SHALL go to FIRST; if raw_bit differs from the pair bit, the pair bit SHALL be emitted (01->0, 10->1); if they are equal, nothing SHALL be emitted (von Neumann debias).
REQ-019 Each emitted bit SHALL shift into an 8-bit shifter MSB-first (shifter <= {shifter[6:0], bit}), and a 3-bit bit counter SHALL wrap 7->0.
REQ-020 On the 8th emitted bit, the completed byte SHALL be pushed into the FIFO on that same edge; byte_valid SHALL be visible the next cycle (1-cycle latency from the completing sample).
REQ-021 A push to a full FIFO SHALL drop the byte and set overflow, unless a pop happens on the same edge, in which case both the push and the pop SHALL succeed.
REQ-022 A pop SHALL occur when byte_valid=1 and byte_ready=1; byte_out SHALL be stable while byte_valid=1 and byte_ready=0.
REQ-023 A push and a pop on the same edge SHALL leave fifo_count unchanged; fifo_count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-024 A 8-bit repetition counter SHALL count consecutive identical sampled raw bits (1 on the first sample, reset to 1 when the value changes) and SHALL saturate.
REQ-025 When the repetition counter reaches REP_LIMIT, health_fail SHALL set and the FSM SHALL enter FAULT; the same sample SHALL NOT produce a push.
REQ-026 FAULT SHALL ignore samples; the FIFO SHALL keep draining normally; only clear or reset SHALL exit FAULT.
REQ-027 When clear=1, the FSM SHALL go to IDLE, and the shifter, bit counter, pair bit, repetition counter, FIFO pointers, overflow and health_fail SHALL all be zeroed on that edge; clear SHALL override a simultaneous push/pop.
REQ-028 The pointer width SHALL be log2(FIFO_DEPTH), and pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 When rst_n=0, the FSM SHALL go to IDLE immediately, and byte_out=0x00, byte_valid=0, fifo_count=0, overflow=0 and health_fail=0, with the shifter and all counters at 0.
REQ-030 Reset assertion mid-byte or mid-pair SHALL discard the partial data; release SHALL be synchronised so that the first sample is taken no earlier than the second edge after deassertion.

Verification
REQ-031 The bench SHALL check: enable=1, raw_valid=1, raw stream 0,1,0,1... (16 samples) -> one byte 0x00, byte_valid=1 one cycle after the 16th sample, fifo_count=1.
REQ-032 The bench SHALL check: raw stream 1,0 repeated 8 times, then 0,0,1,1 -> byte 0xFF, and the 00/11 pairs produce no emitted bit.
REQ-033 The bench SHALL check: byte_ready=0 while 5 bytes complete with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, and the head byte is unchanged.
REQ-034 The bench SHALL check: FIFO full with byte_ready=1 on the edge the 5th byte completes -> no overflow, fifo_count stays 4.
REQ-035 The bench SHALL check: raw_bit held at 1 for 16 samples -> health_fail=1 on the 16th, FSM in FAULT, no further pushes; clear=1 for 1 cycle -> all flags 0 and fifo_count=0.
REQ-036 The bench SHALL check: rst_n pulsed low mid-byte (5 bits shifted) -> byte_valid=0 and fifo_count=0 immediately, and the next full byte is built from post-reset samples only.
